multicycle_controller: RTL and testbench

- Multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback for each instruction.
- It drives the datapath muxes, the register-file and memory strobes, and the ALU operation code.
- It consumes the ALU zero flag for beq. It is the control end of the ALU interface: it issues ops and receives zero.
- It sits between the instruction register (opcode/funct) and the shared multicycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/alu_op_decoder.sv | 40 ++++
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, functs, ALU ops,
// datapath mux selects, state encodings and a state-class helper.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnSlt = 6'b101010;

    // Shared with the ALU
    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluSlt = 2'b10;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDst31 = 2'b10;

    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMdr = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    localparam logic SrcAPc  = 1'b0;
    localparam logic SrcAReg = 1'b1;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11,
        StJal     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsFetch,
        ClsDecode,
        ClsMemAddr,
        ClsRExec,
        ClsIExec,
        ClsBranch
    } state_cls_e;

    function automatic state_cls_e state_class(state_e s);
        case (s)
            StFetch:   return ClsFetch;
            StDecode:  return ClsDecode;
            StMemAddr: return ClsMemAddr;
            StRExec:   return ClsRExec;
            StIExec:   return ClsIExec;
            StBranch:  return ClsBranch;
            default:   return ClsNone;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the shared datapath (slave).
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       fault;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, fault, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, fault, state_dbg
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational ALU-op and illegal-instruction decode per state class.
// MC_JAL_EN makes opcode 000011 (jal) legal in DECODE.
module alu_op_decoder
    import mips_ctrl_pkg::*;
(
    input  state_cls_e cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [1:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = AluAdd;
        illegal = 1'b0;
        case (cls)
            ClsDecode: begin
                case (opcode)
                    OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpSlti: illegal = 1'b0;
`ifdef MC_JAL_EN
                    OpJal:   illegal = 1'b0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            ClsRExec: begin
                case (funct)
                    FnAdd:   alu_op = AluAdd;
                    FnSub:   alu_op = AluSub;
                    FnSlt:   alu_op = AluSlt;
                    default: illegal = 1'b1;
                endcase
            end
            ClsIExec:  alu_op = (opcode == OpSlti) ? AluSlt : AluAdd;
            ClsBranch: alu_op = AluSub;
            default:   alu_op = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-wait timeout.
// MC_JAL_EN adds the JAL state (otherwise opcode 000011 faults).
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_controller_if.master bus
);

    localparam int unsigned WaitW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    state_cls_e       cls;
    logic [1:0]       dec_alu_op;
    logic             illegal;
    logic             in_mem;
    logic             timeout;

    assign cls = state_class(state_q);

    alu_op_decoder u_alu_op_decoder (
        .cls     (cls),
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .alu_op  (dec_alu_op),
        .illegal (illegal)
    );

    // Current cycle would be the MEM_WAIT_MAX-th without mem_ready
    assign in_mem  = state_q inside {StFetch, StMemRd, StMemWr};
    assign timeout = in_mem && !bus.mem_ready && (wait_q == WaitLast);
    assign wait_d  = (in_mem && !bus.mem_ready && !timeout) ? wait_q + WaitW'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pc_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = RegDstRt;
        bus.mem_to_reg = MemToRegAlu;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = SrcAPc;
        bus.alu_src_b  = SrcBReg;
        bus.pc_src     = PcSrcAlu;
        bus.fault      = 1'b0;
        case (state_q)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SrcBFour;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = StDecode;
                end else if (timeout) begin
                    bus.fault = 1'b1;
                end
            end
            StDecode: begin
                bus.alu_src_b = SrcBImmSh;
                if (illegal) begin
                    bus.fault = 1'b1;
                    state_d   = StFetch;
                end else begin
                    case (bus.opcode)
                        OpRtype:        state_d = StRExec;
                        OpLw, OpSw:     state_d = StMemAddr;
                        OpBeq:          state_d = StBranch;
                        OpJ:            state_d = StJump;
                        OpAddi, OpSlti: state_d = StIExec;
`ifdef MC_JAL_EN
                        OpJal:          state_d = StJal;
`endif
                        default:        state_d = StFetch;
                    endcase
                end
            end
            StMemAddr: begin
                bus.alu_src_a = SrcAReg;
                bus.alu_src_b = SrcBImm;
                state_d       = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    bus.fault = 1'b1;
                    state_d   = StFetch;
                end
            end
            StMemWb: begin
                bus.mem_to_reg = MemToRegMdr;
                bus.reg_write  = 1'b1;
                state_d        = StFetch;
            end
            StMemWr: begin
                bus.iord      = 1'b1;
                bus.mem_write = !timeout;
                if (bus.mem_ready) begin
                    state_d = StFetch;
                end else if (timeout) begin
                    bus.fault = 1'b1;
                    state_d   = StFetch;
                end
            end
            StRExec: begin
                bus.alu_src_a = SrcAReg;
                bus.alu_src_b = SrcBReg;
                bus.fault     = illegal;
                state_d       = illegal ? StFetch : StRWb;
            end
            StRWb: begin
                bus.reg_dst   = RegDstRd;
                bus.reg_write = 1'b1;
                state_d       = StFetch;
            end
            StIExec: begin
                bus.alu_src_a = SrcAReg;
                bus.alu_src_b = SrcBImm;
                state_d       = StIWb;
            end
            StIWb: begin
                bus.reg_write = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                bus.alu_src_a = SrcAReg;
                bus.alu_src_b = SrcBReg;
                bus.pc_src    = PcSrcAluOut;
                bus.pc_write  = bus.zero;
                state_d       = StFetch;
            end
            StJump: begin
                bus.pc_src   = PcSrcJump;
                bus.pc_write = 1'b1;
                state_d      = StFetch;
            end
`ifdef MC_JAL_EN
            StJal: begin
                bus.reg_dst    = RegDst31;
                bus.mem_to_reg = MemToRegPc;
                bus.reg_write  = 1'b1;
                bus.pc_src     = PcSrcJump;
                bus.pc_write   = 1'b1;
                state_d        = StFetch;
            end
`endif
            default: state_d = StFetch;
        endcase

        // FETCH decode would otherwise leak mem_read and selects during reset
        if (rst) begin
            bus.pc_write   = 1'b0;
            bus.iord       = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_dst    = 2'b00;
            bus.mem_to_reg = 2'b00;
            bus.reg_write  = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = 2'b00;
            bus.pc_src     = 2'b00;
            bus.fault      = 1'b0;
        end
    end

    assign bus.alu_op    = rst ? 2'b00 : dec_alu_op;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed table, random instructions against an
// instruction-level reference model, plus reset and memory-timeout sequences.
module tb_multicycle_controller;

`ifdef MC_JAL_EN
    localparam bit JalEn = 1'b1;
`else
    localparam bit JalEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observations of one instruction
    int obs_state[$];
    int obs_rdy[$];
    int n_rw, n_pw, n_iw, n_mw, n_mr, n_fault, n_both;
    int wr_dst, wr_mtr, alu_seen, jmp_pc_src, ncyc;

    // Runs one instruction from FETCH until the FSM returns to FETCH (bounded).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int rdy_pct);
        bit left = 1'b0;
        obs_state.delete();
        obs_rdy.delete();
        n_rw = 0; n_pw = 0; n_iw = 0; n_mw = 0; n_mr = 0; n_fault = 0; n_both = 0;
        wr_dst = -1; wr_mtr = -1; alu_seen = -1; jmp_pc_src = -1; ncyc = -1;
        for (int c = 0; c < 64; c++) begin
            bus.opcode    = op;
            bus.funct     = fn;
            bus.zero      = z;
            bus.mem_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            obs_state.push_back(int'(bus.state_dbg));
            obs_rdy.push_back(bus.mem_ready ? 1 : 0);
            if (bus.state_dbg != 4'd0) left = 1'b1;
            if (bus.reg_write) begin
                n_rw++;
                wr_dst = int'(bus.reg_dst);
                wr_mtr = int'(bus.mem_to_reg);
            end
            if (bus.pc_write) n_pw++;
            if (bus.ir_write) n_iw++;
            if (bus.mem_write) n_mw++;
            if (bus.mem_read) n_mr++;
            if (bus.fault) n_fault++;
            if (bus.mem_read && bus.mem_write) n_both++;
            if (bus.state_dbg inside {4'd6, 4'd8, 4'd10}) alu_seen = int'(bus.alu_op);
            if (bus.pc_write && bus.state_dbg != 4'd0) jmp_pc_src = int'(bus.pc_src);
            @(posedge clk);
            #1;
            if (left && bus.state_dbg == 4'd0) begin
                ncyc = c + 1;
                break;
            end
        end
        if (ncyc < 0) $display("FAIL instr_timeout: got no return to FETCH expected <=64 cycles");
    endtask

    // Reference model: phase list from the instruction, stretched by the observed
    // mem_ready pattern in the memory phases, plus the expected side effects.
    task automatic score(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int path[$];
        int exp_seq[$];
        int i = 0;
        int first_bad = -1;
        int n;
        bit fn_ok = fn inside {6'b100000, 6'b100010, 6'b101010};
        int e_rw = 0, e_pw = 1, e_flt = 0, e_dst = -1, e_mtr = -1, e_alu = -1, e_pcs = -1;
        int e_mw = 0, e_mr = 0;
        path.push_back(0);
        path.push_back(1);
        case (op)
            6'b000000: begin
                path.push_back(6);
                if (fn_ok) begin
                    path.push_back(7);
                    e_rw = 1; e_dst = 1; e_mtr = 0;
                    e_alu = (fn == 6'b100000) ? 0 : (fn == 6'b100010) ? 1 : 2;
                end else begin
                    e_flt = 1; e_alu = -2;
                end
            end
            6'b100011: begin
                path.push_back(2); path.push_back(3); path.push_back(4);
                e_rw = 1; e_dst = 0; e_mtr = 1;
            end
            6'b101011: begin
                path.push_back(2); path.push_back(5);
            end
            6'b000100: begin
                path.push_back(8);
                e_alu = 1;
                if (z) begin e_pw = 2; e_pcs = 1; end
            end
            6'b000010: begin
                path.push_back(9);
                e_pw = 2; e_pcs = 2;
            end
            6'b001000: begin
                path.push_back(10); path.push_back(11);
                e_rw = 1; e_dst = 0; e_mtr = 0; e_alu = 0;
            end
            6'b001010: begin
                path.push_back(10); path.push_back(11);
                e_rw = 1; e_dst = 0; e_mtr = 0; e_alu = 2;
            end
            6'b000011: begin
                if (JalEn) begin
                    path.push_back(12);
                    e_rw = 1; e_dst = 2; e_mtr = 2; e_pw = 2; e_pcs = 2;
                end else begin
                    e_flt = 1;
                end
            end
            default: e_flt = 1;
        endcase
        foreach (path[k]) begin
            if (path[k] inside {0, 3, 5}) begin
                while (i < obs_rdy.size() && obs_rdy[i] == 0) begin
                    exp_seq.push_back(path[k]);
                    i++;
                end
            end
            exp_seq.push_back(path[k]);
            i++;
        end
        foreach (exp_seq[k]) begin
            if (exp_seq[k] == 5) e_mw++;
            if (exp_seq[k] == 0 || exp_seq[k] == 3) e_mr++;
        end
        n = (obs_state.size() < exp_seq.size()) ? obs_state.size() : exp_seq.size();
        for (int k = 0; k < n; k++) begin
            if (first_bad < 0 && obs_state[k] != exp_seq[k]) first_bad = k;
        end
        check("cycles", ncyc, exp_seq.size());
        check("state_path_first_bad_idx", first_bad, -1);
        check("reg_write_count", n_rw, e_rw);
        check("pc_write_count", n_pw, e_pw);
        check("ir_write_count", n_iw, 1);
        check("mem_write_cycles", n_mw, e_mw);
        check("mem_read_cycles", n_mr, e_mr);
        check("fault_count", n_fault, e_flt);
        check("rd_and_wr_overlap", n_both, 0);
        check("reg_dst_at_write", wr_dst, e_dst);
        check("mem_to_reg_at_write", wr_mtr, e_mtr);
        check("pc_src_at_jump", jmp_pc_src, e_pcs);
        if (e_alu != -2) check("alu_op_exec", alu_seen, e_alu);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cyc;
        int         rw;
        int         pw;
        int         flt;
    } vec_t;

    function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic z, int cyc, int rw,
                                int pw, int flt);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.cyc = cyc; v.rw = rw; v.pw = pw; v.flt = flt;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [5:0] ops[10];
        logic [5:0] fns[4];
        bit found;
        int fault_at, nf, niw;

        tbl.push_back(mk(6'b100011, 6'b000000, 1'b0, 5, 1, 1, 0));  // lw
        tbl.push_back(mk(6'b101011, 6'b000000, 1'b0, 4, 0, 1, 0));  // sw
        tbl.push_back(mk(6'b000000, 6'b100000, 1'b0, 4, 1, 1, 0));  // add
        tbl.push_back(mk(6'b000000, 6'b100010, 1'b0, 4, 1, 1, 0));  // sub
        tbl.push_back(mk(6'b000000, 6'b101010, 1'b0, 4, 1, 1, 0));  // slt
        tbl.push_back(mk(6'b000000, 6'b001000, 1'b0, 3, 0, 1, 1));  // bad funct
        tbl.push_back(mk(6'b001000, 6'b000000, 1'b0, 4, 1, 1, 0));  // addi
        tbl.push_back(mk(6'b001010, 6'b000000, 1'b0, 4, 1, 1, 0));  // slti
        tbl.push_back(mk(6'b000100, 6'b000000, 1'b1, 3, 0, 2, 0));  // beq taken
        tbl.push_back(mk(6'b000100, 6'b000000, 1'b0, 3, 0, 1, 0));  // beq not taken
        tbl.push_back(mk(6'b000010, 6'b000000, 1'b0, 3, 0, 2, 0));  // j
        tbl.push_back(mk(6'b000011, 6'b000000, 1'b0, JalEn ? 3 : 2, JalEn ? 1 : 0,
                         JalEn ? 2 : 1, JalEn ? 0 : 1));           // jal
        tbl.push_back(mk(6'b111111, 6'b000000, 1'b0, 2, 0, 1, 1));  // illegal opcode

        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                6'b001000, 6'b001010, 6'b000011, 6'b111111, 6'b010001};
        fns = '{6'b100000, 6'b100010, 6'b101010, 6'b000000};

        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #2;
        check("rst_state", int'(bus.state_dbg), 0);
        check("rst_mem_read", int'(bus.mem_read), 0);
        check("rst_ir_write", int'(bus.ir_write), 0);
        check("rst_pc_write", int'(bus.pc_write), 0);
        check("rst_alu_src_b", int'(bus.alu_src_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[t]) begin
            run_instr(tbl[t].op, tbl[t].fn, tbl[t].z, 100);
            check("tbl_cycles", ncyc, tbl[t].cyc);
            check("tbl_reg_write", n_rw, tbl[t].rw);
            check("tbl_pc_write", n_pw, tbl[t].pw);
            check("tbl_fault", n_fault, tbl[t].flt);
            score(tbl[t].op, tbl[t].fn, tbl[t].z);
        end

        for (int r = 0; r < 40; r++) begin
            logic [5:0] op, fn;
            logic z;
            op = ops[$urandom_range(9)];
            fn = ($urandom_range(3) == 3) ? 6'($urandom) : fns[$urandom_range(2)];
            z  = 1'($urandom);
            run_instr(op, fn, z, 75);
            score(op, fn, z);
        end

        // Reset in MEM_RD while waiting on memory
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            bus.opcode = 6'b100011; bus.mem_ready = 1'b1;
            @(negedge clk);
            if (bus.state_dbg == 4'd3) begin
                found = 1'b1;
                bus.mem_ready = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("reach_mem_rd", int'(found), 1);
        @(negedge clk);
        check("mem_rd_waiting", int'(bus.state_dbg), 3);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_state", int'(bus.state_dbg), 0);
        check("midrst_mem_read", int'(bus.mem_read), 0);
        check("midrst_reg_write", int'(bus.reg_write), 0);
        check("midrst_mem_to_reg", int'(bus.mem_to_reg), 0);
        check("midrst_iord", int'(bus.iord), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("postrst_state", int'(bus.state_dbg), 0);
        check("postrst_mem_read", int'(bus.mem_read), 1);
        check("postrst_reg_write", int'(bus.reg_write), 0);
        @(posedge clk);
        #1;
        run_instr(6'b111111, 6'b000000, 1'b0, 100);
        check("postrst_no_writeback", n_rw, 0);
        check("postrst_illegal_fault", n_fault, 1);

        // FETCH memory timeout
        fault_at = -1; nf = 0; niw = 0;
        for (int c = 1; c <= 16; c++) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
            if (bus.fault) begin nf++; fault_at = c; end
            if (bus.ir_write) niw++;
            @(posedge clk);
            #1;
        end
        check("timeout_fault_count", nf, 1);
        check("timeout_fault_cycle", fault_at, 15);
        check("timeout_ir_write", niw, 0);
        check("timeout_restart_state", int'(bus.state_dbg), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
